// File: rtl/bcd_stopwatch_ctrl.sv
// rtl/bcd_stopwatch_ctrl.sv - four-digit BCD stopwatch sequencer with prescaler, lap hold and sticky overflow
module bcd_stopwatch_ctrl #(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [15:0] disp,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_LAP
    } state_t;

    state_t            state;
    logic [PW-1:0]     presc;
    logic [3:0][3:0]   digits;
    logic [15:0]       hold;
    logic              counting;
    logic              tick;
    logic [3:0]        inc;
    logic              wrap;

    // Each digit steps only when every lower digit is about to roll over.
    always_comb begin
        counting = (state == S_RUN) || (state == S_LAP);
        tick     = counting && (presc == PRESC_MAX);
        inc      = '0;
        inc[0]   = tick;
        for (int i = 1; i < 4; i++) begin
            inc[i] = inc[i-1] && (digits[i-1] == 4'd9);
        end
        wrap = inc[3] && (digits[3] == 4'd9);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
            hold       <= '0;
            presc      <= '0;
            overflow   <= 1'b0;
            digits     <= '0;
        end else begin
            if (counting) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (inc[i]) begin
                    digits[i] <= (digits[i] == 4'd9) ? 4'd0 : digits[i] + 4'd1;
                end
            end
            if (wrap) begin
                overflow <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_stop) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (start_stop) begin
                        state   <= S_PAUSE;
                        running <= 1'b0;
                    end else if (lap) begin
                        state      <= S_LAP;
                        lap_active <= 1'b1;
                        hold       <= digits;
                    end
                end
                S_LAP: begin
                    if (start_stop) begin
                        state      <= S_PAUSE;
                        running    <= 1'b0;
                        lap_active <= 1'b0;
                    end else if (lap) begin
                        state      <= S_RUN;
                        lap_active <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    // The prescaler is frozen here, so a clear has no tick to race against.
                    if (clear) begin
                        state    <= S_IDLE;
                        digits   <= '0;
                        presc    <= '0;
                        overflow <= 1'b0;
                    end else if (start_stop) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    running    <= 1'b0;
                    lap_active <= 1'b0;
                end
            endcase
        end
    end

    assign disp = lap_active ? hold : digits;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb/tb_bcd_stopwatch_ctrl.sv - directed scoreboard bench for bcd_stopwatch_ctrl
module tb_bcd_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic [15:0] disp;
    logic        running;
    logic        lap_active;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    int m_state;
    int m_count;
    int m_hold;
    int m_presc;
    bit m_ovf;

    logic [18:0] exp_q[$];

    bcd_stopwatch_ctrl #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .disp       (disp),
        .running    (running),
        .lap_active (lap_active),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [18:0] model_out();
        logic [15:0] d;
        d = (m_state == M_LAP) ? to_bcd(m_hold) : to_bcd(m_count);
        return {d, (m_state == M_RUN || m_state == M_LAP), (m_state == M_LAP), m_ovf};
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_count = 0;
        m_hold  = 0;
        m_presc = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit l, input bit c);
        bit act;
        bit tk;
        int old;
        old = m_count;
        act = (m_state == M_RUN) || (m_state == M_LAP);
        tk  = act && (m_presc == TD - 1);
        if (act) m_presc = tk ? 0 : m_presc + 1;
        if (tk) begin
            if (m_count == 9999) begin
                m_count = 0;
                m_ovf   = 1'b1;
            end else begin
                m_count = m_count + 1;
            end
        end
        case (m_state)
            M_IDLE:  if (s) m_state = M_RUN;
            M_RUN:   if (s) m_state = M_PAUSE;
                     else if (l) begin m_state = M_LAP; m_hold = old; end
            M_LAP:   if (s) m_state = M_PAUSE;
                     else if (l) m_state = M_RUN;
            default: if (c) begin
                         m_state = M_IDLE; m_count = 0; m_presc = 0; m_ovf = 1'b0;
                     end else if (s) m_state = M_RUN;
        endcase
    endtask

    task automatic check_val(input string tag, input logic [18:0] obs, input logic [18:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_q(input string tag);
        logic [18:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, {disp, running, lap_active, overflow}, e);
        end
    endtask

    task automatic step(input bit s, input bit l, input bit c, input string tag);
        start_stop = s;
        lap        = l;
        clear      = c;
        model_edge(s, l, c);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        check_q(tag);
    endtask

    task automatic run_until_count(input int target, input string tag);
        int n = 0;
        while (m_count != target && n < 50000) begin
            step(0, 0, 0, tag);
            n++;
        end
    endtask

    task automatic run_until_presc(input int target, input string tag);
        int n = 0;
        while (m_presc != target && n < 10) begin
            step(0, 0, 0, tag);
            n++;
        end
    endtask

    initial begin
        int saved;
        rst        = 1'b0;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        model_reset();
        #3;
        check_val("reset", {disp, running, lap_active, overflow}, 19'h0);
        #9;
        rst = 1'b1;
        @(posedge clk);
        #1;

        step(1, 0, 0, "start");
        check_val("running_after_start", {18'h0, running}, 19'h1);
        repeat (3) step(0, 0, 0, "first_interval");
        check_val("still_0000", {3'h0, disp}, 19'h0000);
        step(0, 0, 0, "first_tick");
        check_val("disp_0001", {3'h0, disp}, 19'h0001);
        repeat (4) step(0, 0, 0, "second_interval");
        check_val("disp_0002", {3'h0, disp}, 19'h0002);

        run_until_count(10, "to_0010");
        check_val("disp_0010", {3'h0, disp}, 19'h0010);
        run_until_count(1000, "to_1000");
        check_val("disp_1000", {3'h0, disp}, 19'h1000);
        run_until_count(9999, "to_9999");
        check_val("disp_9999", {3'h0, disp}, 19'h9999);
        run_until_count(0, "wrap");
        check_val("wrap_disp_ovf", {disp, 2'b00, overflow}, {16'h0000, 3'b001});

        step(1, 0, 0, "pause_ovf");
        repeat (5) step(0, 0, 0, "paused_ovf");
        step(1, 0, 0, "resume_ovf");
        check_val("ovf_persists", {18'h0, overflow}, 19'h1);
        step(1, 0, 0, "pause_again");
        step(0, 0, 1, "clear_paused");
        check_val("clear_to_idle", {disp, running, lap_active, overflow}, 19'h0);

        step(1, 0, 0, "restart");
        run_until_count(12, "to_0012");
        step(0, 1, 0, "lap_on");
        check_val("lap_active", {disp, 1'b0, lap_active, 1'b0}, {16'h0012, 3'b010});
        repeat (20) begin
            step(0, 0, 0, "lap_frozen");
            check_val("lap_hold_0012", {3'h0, disp}, 19'h0012);
        end
        step(0, 1, 0, "lap_off");
        check_val("live_0017", {3'h0, disp}, 19'h0017);

        run_until_presc(1, "align_pause");
        step(1, 0, 0, "pause_mid");
        saved = m_count;
        repeat (50) step(0, 0, 0, "paused");
        check_val("pause_hold", {3'h0, disp}, {3'h0, to_bcd(saved)});
        step(1, 0, 0, "resume");
        step(0, 0, 0, "resume_plus1");
        check_val("no_tick_yet", {3'h0, disp}, {3'h0, to_bcd(saved)});
        step(0, 0, 0, "resume_plus2");
        check_val("tick_after_2", {3'h0, disp}, {3'h0, to_bcd(saved + 1)});

        step(0, 0, 1, "clear_in_run");
        check_val("clear_ignored", {18'h0, running}, 19'h1);
        run_until_presc(3, "align_lap_tick");
        saved = m_count;
        step(0, 1, 0, "lap_with_tick");
        check_val("hold_pre_inc", {3'h0, disp}, {3'h0, to_bcd(saved)});
        run_until_presc(3, "align_ss_tick");
        saved = m_count;
        step(1, 0, 0, "ss_with_tick");
        check_val("inc_and_pause", {disp, running}, {to_bcd(saved + 1), 1'b0});
        step(1, 0, 1, "ss_and_clear");
        check_val("clear_wins", {disp, running, lap_active, overflow}, 19'h0);

        step(1, 0, 0, "start_for_reset");
        repeat (9) step(0, 0, 0, "count_for_reset");
        step(0, 1, 0, "lap_for_reset");
        repeat (3) step(0, 0, 0, "lap_run");
        #2;
        rst = 1'b0;
        #1;
        check_val("async_reset", {disp, running, lap_active, overflow}, 19'h0);
        model_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
